mac_ctrl: RTL

MAC_CTRL -- requirements
Module: mac_ctrl

---
 rtl/mac_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/mac_ctrl.sv
// Job sequencer for a 4-lane MAC datapath: issues buffer reads, tracks in-flight groups
// and accumulates qualified results. Define MAC_CTRL_SAT_EN for a saturating accumulator.
module mac_ctrl #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned LEN_W    = 8,
  parameter int unsigned PIPE_LAT = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [ADDR_W-1:0] ifm_base,
  input  logic [ADDR_W-1:0] w_base,
  output logic              rd_en,
  output logic [ADDR_W-1:0] ifm_addr,
  output logic [ADDR_W-1:0] w_addr,
  input  logic [15:0]       mac_result,
  output logic              busy,
  output logic              out_valid,
  output logic [15:0]       out_data,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic [ADDR_W-1:0]   ifm_addr_q, ifm_addr_d;
  logic [ADDR_W-1:0]   w_addr_q, w_addr_d;
  logic [PIPE_LAT-1:0] vld_q, vld_d;
  logic [15:0]         acc_q, acc_d;
  logic [15:0]         out_data_q, out_data_d;
  logic [15:0]         acc_add;
  logic                tap;

  assign tap = vld_q[PIPE_LAT-1];

`ifdef MAC_CTRL_SAT_EN
  logic [16:0] acc_sum;
  // Clamp stays sticky: once at 16'hFFFF any further unsigned add re-clamps.
  always_comb begin
    acc_sum = {1'b0, acc_q} + {1'b0, mac_result};
    acc_add = acc_sum[16] ? 16'hFFFF : acc_sum[15:0];
  end
`else
  always_comb begin
    acc_add = acc_q + mac_result;
  end
`endif

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    ifm_addr_d = ifm_addr_q;
    w_addr_d   = w_addr_q;
    acc_d      = acc_q;
    out_data_d = out_data_q;
    rd_en      = (state_q == ISSUE);

    vld_d[0] = rd_en;
    for (int unsigned i = 1; i < PIPE_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
    end

    if (tap) begin
      acc_d = acc_add;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            ifm_addr_d = ifm_base;
            w_addr_d   = w_base;
            rem_d      = len;
            acc_d      = '0;
            state_d    = ISSUE;
          end else begin
            out_data_d = '0;
            state_d    = FIN;
          end
        end
      end
      ISSUE: begin
        // Addresses only advance between issues so they hold the last issued value.
        if (rem_q == LEN_W'(1)) begin
          state_d = DRAIN;
        end else begin
          rem_d      = rem_q - LEN_W'(1);
          ifm_addr_d = ifm_addr_q + ADDR_W'(1);
          w_addr_d   = w_addr_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        if (vld_d == '0) begin
          out_data_d = acc_d;
          state_d    = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      ifm_addr_q <= '0;
      w_addr_q   <= '0;
      vld_q      <= '0;
      acc_q      <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      ifm_addr_q <= ifm_addr_d;
      w_addr_q   <= w_addr_d;
      vld_q      <= vld_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
    end
  end

  assign ifm_addr  = ifm_addr_q;
  assign w_addr    = w_addr_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIN);
  assign out_valid = (state_q == FIN);

endmodule
